sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Parametrised N-channel request arbiter in front of the `sdramburst` controller, running in the SDRAM-side clock domain. It selects one requester (VGA fetch, MMU cache fill/writeback, and future masters) at a time. It holds the grant for the full burst and routes address, direction, write data and burst length to the controller. It steers the `data_bursting` strobe back to the winner only. It supports an optional strict-priority channel, round-robin or fixed-priority arbitration among the rest, and a per-channel read-only mask.

## Interface
- NUM_CH, 4, number of requesting channels (2..8)
- ADDR_W, 32, address width
- DATA_W, 16, SDRAM data width
- BLEN_W, 2, burst-length field width
- PRIO_EN, 1, 1 = channel PRIO_CH has strict priority over all others
- PRIO_CH, 0, index of the strict-priority channel (video)
- RR_MODE, 1, 1 = round-robin among non-priority channels; 0 = fixed, lowest index wins
- RO_MASK, 0, NUM_CH-bit mask; set bit forces `sd_rw`=0 (read) for that channel

Ports:
- clk  in  1  SDRAM-side clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- ch_rw_req  in  NUM_CH  per-channel request level
- ch_rw  in  NUM_CH  per-channel direction, 1 = write
- ch_address  in  NUM_CH*ADDR_W  packed, channel i at [i*ADDR_W +: ADDR_W]
- ch_write_data  in  NUM_CH*DATA_W  packed write data
- ch_burst_len  in  NUM_CH*BLEN_W  packed burst length
- ch_read_data  out  DATA_W  read data broadcast to all channels
- ch_bursting  out  NUM_CH  data strobe, asserted only for the granted channel
- grant  out  NUM_CH  one-hot registered grant, 0 when idle
- sd_rw_req  out  1  request to controller
- sd_rw  out  1  direction to controller
- sd_address  out  ADDR_W  address to controller
- sd_write_data  out  DATA_W  write data to controller
- sd_burst_len  out  BLEN_W  burst length to controller
- sd_read_data  in  DATA_W  read data from controller
- sd_bursting  in  1  controller data-phase strobe

## Operation
- FSM states: IDLE, REQ, BURST.
- IDLE: if any `ch_rw_req` bit is high, choose a winner and register `grant` one-hot, `sd_rw_req`=1, then go to REQ. Otherwise stay, with `grant`=0 and `sd_rw_req`=0.
- Winner selection:
  - If PRIO_EN and `ch_rw_req[PRIO_CH]` is high, PRIO_CH wins.
  - Otherwise, with RR_MODE=1, the first requesting channel after `rr_ptr`, searching upward and wrapping at NUM_CH-1 to 0, wins. PRIO_CH is skipped by the search when PRIO_EN=1.
  - With RR_MODE=0, the lowest requesting index wins.
  - `rr_ptr` is updated to the winner index on each non-priority grant. A priority grant does not move it.
- REQ: `sd_rw_req` tracks `ch_rw_req[g]` of the granted channel g, registered.
  - If `sd_bursting`=1, go to BURST.
  - If `ch_rw_req[g]` drops while `sd_bursting`=0, the request is cancelled: `grant` clears and the FSM returns to IDLE.
- BURST: `sd_rw_req` keeps tracking `ch_rw_req[g]`. When `sd_bursting` is sampled 0, go to IDLE; `grant` and `sd_rw_req` clear on that edge.
- Datapath is combinational from registered `grant`:
  - `sd_address`, `sd_write_data`, `sd_burst_len` come from channel g.
  - `sd_rw` = `ch_rw[g]` & ~RO_MASK[g].
  - When `grant`=0, these outputs are all zero.
- `ch_bursting[i]` = `sd_bursting` & `grant[i]`. `ch_read_data` = `sd_read_data` unconditionally.
- The grant is never changed while in REQ or BURST. A higher-priority request waits for IDLE.

## Timing
- Reset values: FSM IDLE, `grant`=0, `sd_rw_req`=0, `rr_ptr`=NUM_CH-1 (channel 0 is first in round-robin). Outputs derived from `grant` are zero.
- Reset mid-burst: all outputs return to reset values on the next edge, regardless of `sd_bursting`.
- Arbitration latency: request sampled high at edge n in IDLE gives `grant`/`sd_rw_req` high after edge n (visible in cycle n+1).
- End of burst: `sd_bursting` sampled low at edge m clears `grant` after m. IDLE arbitrates at m+1, so the next grant appears after m+1.
  - Minimum one idle cycle between grants. This is required by the controller's `sd_rw_req` edge detection.
- Cancel in REQ: `ch_rw_req[g]` sampled low at edge k clears `grant` after k.
- Simultaneous requests in IDLE: exactly one grant, following the priority rules above. Losing channels keep requesting and get no response.
- `sd_bursting` high while in IDLE (spurious) is ignored and no `ch_bursting` bit is driven.
- `grant` is always one-hot or zero. Verification asserts this every cycle.

## Test plan
- Reset, then idle for 10 cycles: `grant`=0, `sd_rw_req`=0, `sd_address`=0.
- Single request: ch2 requests a write at address 0x0000_1000 with burst_len 2. Required response:
  - `grant`=4'b0100 one cycle later, `sd_address`=0x1000, `sd_rw`=1.
  - `ch_bursting`=4'b0100 only while `sd_bursting` is high.
  - `grant` returns to 0 one cycle after `sd_bursting` falls.
- Priority: ch0 (PRIO_CH) and ch3 request simultaneously. ch0 is granted first. ch3 is granted after ch0's burst plus one idle cycle.
- Round-robin: ch1, ch2 and ch3 hold their requests continuously with PRIO_EN=1 and ch0 silent. Grant order is ch1, ch2, ch3, ch1. Repeating with RR_MODE=0 gives ch1, ch1, ch1.
- RO_MASK=4'b0001: ch0 drives `ch_rw`=1. `sd_rw` stays 0 throughout ch0's grant.
- Cancel and reset:
  - ch1 drops its request in REQ before `sd_bursting` rises: `grant` clears next cycle.
  - Asserting `reset` in the middle of a BURST clears all outputs on the next edge.

Source files
------------

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arbiter
//  Purpose  : N-channel request arbiter in front of the sdramburst controller.
//             Holds one grant for a whole burst, muxes the winner's request
//             fields onto the controller port and steers the data strobe back
//             to the winner only. Optional strict-priority channel, then
//             round-robin or fixed-priority among the remaining channels.
//  Revision : 1.0  initial release
// ============================================================================
module sdram_arbiter #(
  parameter int                NUM_CH  = 4,
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 16,
  parameter int                BLEN_W  = 2,
  parameter int                PRIO_EN = 1,
  parameter int                PRIO_CH = 0,
  parameter int                RR_MODE = 1,
  parameter logic [NUM_CH-1:0] RO_MASK = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_rw_req,
  input  logic [NUM_CH-1:0]        ch_rw,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*DATA_W-1:0] ch_write_data,
  input  logic [NUM_CH*BLEN_W-1:0] ch_burst_len,
  output logic [DATA_W-1:0]        ch_read_data,
  output logic [NUM_CH-1:0]        ch_bursting,
  output logic [NUM_CH-1:0]        grant,
  output logic                     sd_rw_req,
  output logic                     sd_rw,
  output logic [ADDR_W-1:0]        sd_address,
  output logic [DATA_W-1:0]        sd_write_data,
  output logic [BLEN_W-1:0]        sd_burst_len,
  input  logic [DATA_W-1:0]        sd_read_data,
  input  logic                     sd_bursting
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_CH-1:0]  grant_q, grant_d;
  logic               sd_rw_req_q, sd_rw_req_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               win_valid;
  logic               win_prio;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;
  int                 rr_sum;
  logic [NUM_CH-1:0]  win_onehot;
  logic               req_g;

  // Request level of the currently granted channel (0 when nothing granted).
  assign req_g = |(ch_rw_req & grant_q);

  // Winner selection: strict priority channel first, then round-robin or lowest index.
  always_comb begin
    win_valid = 1'b0;
    win_prio  = 1'b0;
    win_idx   = '0;
    cand      = '0;
    rr_sum    = 0;
    if ((PRIO_EN != 0) && ch_rw_req[PRIO_CH]) begin
      win_valid = 1'b1;
      win_prio  = 1'b1;
      win_idx   = PTR_W'(PRIO_CH);
    end else if (RR_MODE != 0) begin
      // Search upward from the channel after the last non-priority winner, wrapping.
      for (int k = 1; k <= NUM_CH; k++) begin
        rr_sum = int'(rr_ptr_q) + k;
        cand   = PTR_W'(rr_sum % NUM_CH);
        if (!win_valid && ch_rw_req[cand] &&
            !((PRIO_EN != 0) && (cand == PTR_W'(PRIO_CH)))) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end else begin
      // Descending scan so the lowest requesting index is the last one written.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (ch_rw_req[i]) begin
          win_valid = 1'b1;
          win_idx   = PTR_W'(i);
        end
      end
    end
    win_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << win_idx;
  end

  // State, grant, request and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      sd_rw_req_q <= 1'b0;
      rr_ptr_q    <= PTR_W'(NUM_CH - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sd_rw_req_q <= sd_rw_req_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Next-state logic: grant is only ever loaded in IDLE and held through REQ/BURST.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sd_rw_req_d = sd_rw_req_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        grant_d     = '0;
        sd_rw_req_d = 1'b0;
        if (win_valid) begin
          grant_d     = win_onehot;
          sd_rw_req_d = 1'b1;
          state_d     = S_REQ;
          if (!win_prio) begin
            rr_ptr_d = win_idx;
          end
        end
      end
      S_REQ: begin
        sd_rw_req_d = req_g;
        if (sd_bursting) begin
          state_d = S_BURST;
        end else if (!req_g) begin
          // Requester withdrew before the controller started the burst.
          state_d     = S_IDLE;
          grant_d     = '0;
          sd_rw_req_d = 1'b0;
        end
      end
      S_BURST: begin
        sd_rw_req_d = req_g;
        if (!sd_bursting) begin
          state_d     = S_IDLE;
          grant_d     = '0;
          sd_rw_req_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        grant_d     = '0;
        sd_rw_req_d = 1'b0;
      end
    endcase
  end

  // AND-OR mux of the granted channel's fields; all zero when grant is zero.
  always_comb begin
    sd_address    = '0;
    sd_write_data = '0;
    sd_burst_len  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q[i]) begin
        sd_address    = sd_address    | ch_address[i*ADDR_W +: ADDR_W];
        sd_write_data = sd_write_data | ch_write_data[i*DATA_W +: DATA_W];
        sd_burst_len  = sd_burst_len  | ch_burst_len[i*BLEN_W +: BLEN_W];
      end
    end
  end

  assign sd_rw        = |(grant_q & ch_rw & ~RO_MASK);
  assign sd_rw_req    = sd_rw_req_q;
  assign grant        = grant_q;
  assign ch_bursting  = {NUM_CH{sd_bursting}} & grant_q;
  assign ch_read_data = sd_read_data;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_arbiter
//  Purpose  : Directed self-checking bench for sdram_arbiter. Instance A uses
//             the default configuration; instance B is fixed-priority with
//             channel 0 read-only. Both share every input.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   ch_rw_req;
  logic [3:0]   ch_rw;
  logic [127:0] ch_address;
  logic [63:0]  ch_write_data;
  logic [7:0]   ch_burst_len;
  logic [15:0]  sd_read_data;
  logic         sd_bursting;

  logic [15:0]  a_ch_read_data, b_ch_read_data;
  logic [3:0]   a_ch_bursting,  b_ch_bursting;
  logic [3:0]   a_grant,        b_grant;
  logic         a_sd_rw_req,    b_sd_rw_req;
  logic         a_sd_rw,        b_sd_rw;
  logic [31:0]  a_sd_address,   b_sd_address;
  logic [15:0]  a_sd_write_data, b_sd_write_data;
  logic [1:0]   a_sd_burst_len, b_sd_burst_len;

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;

  sdram_arbiter dut_a (
    .clk(clk), .reset(rst),
    .ch_rw_req(ch_rw_req), .ch_rw(ch_rw), .ch_address(ch_address),
    .ch_write_data(ch_write_data), .ch_burst_len(ch_burst_len),
    .ch_read_data(a_ch_read_data), .ch_bursting(a_ch_bursting), .grant(a_grant),
    .sd_rw_req(a_sd_rw_req), .sd_rw(a_sd_rw), .sd_address(a_sd_address),
    .sd_write_data(a_sd_write_data), .sd_burst_len(a_sd_burst_len),
    .sd_read_data(sd_read_data), .sd_bursting(sd_bursting)
  );

  sdram_arbiter #(.RR_MODE(0), .RO_MASK(4'b0001)) dut_b (
    .clk(clk), .reset(rst),
    .ch_rw_req(ch_rw_req), .ch_rw(ch_rw), .ch_address(ch_address),
    .ch_write_data(ch_write_data), .ch_burst_len(ch_burst_len),
    .ch_read_data(b_ch_read_data), .ch_bursting(b_ch_bursting), .grant(b_grant),
    .sd_rw_req(b_sd_rw_req), .sd_rw(b_sd_rw), .sd_address(b_sd_address),
    .sd_write_data(b_sd_write_data), .sd_burst_len(b_sd_burst_len),
    .sd_read_data(sd_read_data), .sd_bursting(sd_bursting)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Grant must be one-hot or zero on every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("onehot_a", {63'd0, $onehot0(a_grant)}, 64'd1);
      check("onehot_b", {63'd0, $onehot0(b_grant)}, 64'd1);
    end
  end

  logic [3:0] exp_a [4] = '{4'h2, 4'h4, 4'h8, 4'h2};
  logic [3:0] exp_b [4] = '{4'h2, 4'h2, 4'h2, 4'h2};

  initial begin
    rst = 1'b1;
    ch_rw_req = '0; ch_rw = '0; ch_address = '0; ch_write_data = '0;
    ch_burst_len = '0; sd_read_data = '0; sd_bursting = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_grant", 64'(a_grant), 64'h0);
      check("idle_req", 64'(a_sd_rw_req), 64'h0);
      check("idle_addr", 64'(a_sd_address), 64'h0);
    end
    check("idle_grant_b", 64'(b_grant), 64'h0);

    // Read data broadcast
    sd_read_data = 16'hA5C3;
    #1 check("rdata", 64'(a_ch_read_data), 64'hA5C3);

    // Spurious strobe in IDLE
    sd_bursting = 1'b1;
    #1 check("spur_bursting", 64'(a_ch_bursting), 64'h0);
    @(negedge clk);
    check("spur_grant", 64'(a_grant), 64'h0);
    check("spur_bursting2", 64'(a_ch_bursting), 64'h0);
    sd_bursting = 1'b0;

    // Single write request on ch2
    ch_address[64 +: 32]   = 32'h0000_1000;
    ch_rw                  = 4'b0100;
    ch_burst_len[4 +: 2]   = 2'd2;
    ch_write_data[32 +: 16] = 16'hBEEF;
    ch_rw_req              = 4'b0100;
    @(negedge clk);
    check("single_grant", 64'(a_grant), 64'h4);
    check("single_req", 64'(a_sd_rw_req), 64'h1);
    check("single_addr", 64'(a_sd_address), 64'h1000);
    check("single_rw", 64'(a_sd_rw), 64'h1);
    check("single_blen", 64'(a_sd_burst_len), 64'h2);
    check("single_wdata", 64'(a_sd_write_data), 64'hBEEF);
    check("single_nostrobe", 64'(a_ch_bursting), 64'h0);
    sd_bursting = 1'b1;
    #1 check("single_strobe", 64'(a_ch_bursting), 64'h4);
    @(negedge clk);
    check("single_strobe2", 64'(a_ch_bursting), 64'h4);
    check("single_hold", 64'(a_grant), 64'h4);
    sd_bursting = 1'b0;
    ch_rw_req = 4'b0000;
    #1 check("single_strobe_off", 64'(a_ch_bursting), 64'h0);
    check("single_hold2", 64'(a_grant), 64'h4);
    @(negedge clk);
    check("single_end_grant", 64'(a_grant), 64'h0);
    check("single_end_req", 64'(a_sd_rw_req), 64'h0);
    check("single_end_addr", 64'(a_sd_address), 64'h0);

    // Priority: ch0 and ch3 together
    ch_rw = 4'b0000;
    ch_address[0 +: 32]  = 32'h0000_2000;
    ch_address[96 +: 32] = 32'h0000_3000;
    ch_rw_req = 4'b1001;
    @(negedge clk);
    check("prio_grant_a", 64'(a_grant), 64'h1);
    check("prio_grant_b", 64'(b_grant), 64'h1);
    check("prio_addr", 64'(a_sd_address), 64'h2000);
    sd_bursting = 1'b1;
    ch_rw_req = 4'b1000;
    @(negedge clk);
    check("prio_burst_hold", 64'(a_grant), 64'h1);
    check("prio_req_track", 64'(a_sd_rw_req), 64'h0);
    sd_bursting = 1'b0;
    @(negedge clk);
    check("prio_gap", 64'(a_grant), 64'h0);
    @(negedge clk);
    check("prio_second", 64'(a_grant), 64'h8);
    check("prio_second_addr", 64'(a_sd_address), 64'h3000);
    ch_rw_req = 4'b0000;
    @(negedge clk);
    check("prio_done", 64'(a_grant), 64'h0);

    // Round-robin (A) vs fixed priority (B) with ch1..ch3 held
    ch_rw_req = 4'b1110;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check("rr_grant_a", 64'(a_grant), 64'(exp_a[g]));
      check("fx_grant_b", 64'(b_grant), 64'(exp_b[g]));
      if (g < 3) begin
        sd_bursting = 1'b1;
        @(negedge clk);
        sd_bursting = 1'b0;
        @(negedge clk);
        check("rr_gap", 64'(a_grant), 64'h0);
      end
    end
    ch_rw_req = 4'b0000;
    @(negedge clk);
    check("rr_done", 64'(a_grant), 64'h0);

    // Read-only mask on ch0 in B
    ch_rw = 4'b0001;
    ch_address[0 +: 32] = 32'h0000_4000;
    ch_rw_req = 4'b0001;
    @(negedge clk);
    check("ro_grant_b", 64'(b_grant), 64'h1);
    check("ro_rw_a", 64'(a_sd_rw), 64'h1);
    check("ro_rw_b", 64'(b_sd_rw), 64'h0);
    sd_bursting = 1'b1;
    @(negedge clk);
    check("ro_rw_b_burst", 64'(b_sd_rw), 64'h0);
    check("ro_strobe_b", 64'(b_ch_bursting), 64'h1);
    sd_bursting = 1'b0;
    ch_rw_req = 4'b0000;
    @(negedge clk);
    check("ro_end_b", 64'(b_grant), 64'h0);
    check("ro_end_rw_b", 64'(b_sd_rw), 64'h0);

    // Cancel in REQ
    ch_rw = 4'b0000;
    ch_address[32 +: 32] = 32'h0000_5000;
    ch_rw_req = 4'b0010;
    @(negedge clk);
    check("cancel_grant", 64'(a_grant), 64'h2);
    check("cancel_req", 64'(a_sd_rw_req), 64'h1);
    ch_rw_req = 4'b0000;
    @(negedge clk);
    check("cancel_cleared", 64'(a_grant), 64'h0);
    check("cancel_req_cleared", 64'(a_sd_rw_req), 64'h0);

    // Reset in the middle of a burst
    ch_rw_req = 4'b0100;
    @(negedge clk);
    check("rstb_grant", 64'(a_grant), 64'h4);
    sd_bursting = 1'b1;
    @(negedge clk);
    check("rstb_hold", 64'(a_grant), 64'h4);
    rst = 1'b1;
    @(negedge clk);
    check("rstb_grant_clr", 64'(a_grant), 64'h0);
    check("rstb_req_clr", 64'(a_sd_rw_req), 64'h0);
    check("rstb_addr_clr", 64'(a_sd_address), 64'h0);
    check("rstb_wdata_clr", 64'(a_sd_write_data), 64'h0);
    check("rstb_blen_clr", 64'(a_sd_burst_len), 64'h0);
    check("rstb_strobe_clr", 64'(a_ch_bursting), 64'h0);
    rst = 1'b0;
    sd_bursting = 1'b0;
    ch_rw_req = 4'b0000;
    @(negedge clk);
    check("rstb_idle", 64'(a_grant), 64'h0);

    // Round-robin pointer restarts after reset: ch1 first again
    ch_rw_req = 4'b1110;
    @(negedge clk);
    check("rr_after_rst", 64'(a_grant), 64'h2);
    ch_rw_req = 4'b0000;
    @(negedge clk);
    check("rr_after_rst_done", 64'(a_grant), 64'h0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
